// File: rtl/keypad_conditioner_pkg.sv
// Shared constants and width helpers for the keypad conditioner.
// Latency: none (compile-time only).
// Backpressure: none (no handshake; pulses are fire-and-forget).
package keypad_pkg;

  localparam int DEF_NUM_KEYS        = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 8;
  localparam int DEF_REPEAT_PERIOD   = 3;

  // Width of the key index; never narrower than one bit.
  function automatic int key_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int KEY_IDX_W = key_idx_w(DEF_NUM_KEYS);

endpackage

// File: rtl/keypad_conditioner_if.sv
// Pad-side and control-side signal bundle of the keypad conditioner.
// Latency: none (wiring only).
// Backpressure: none; consumers must take pulses in the cycle they appear.
interface keypad_conditioner_if
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS = DEF_NUM_KEYS
);
  logic [NUM_KEYS-1:0]            keys_i;
  logic                           repeat_en_i;
  logic [NUM_KEYS-1:0]            held_o;
  logic [NUM_KEYS-1:0]            press_o;
  logic [NUM_KEYS-1:0]            release_o;
  logic                           key_valid_o;
  logic [key_idx_w(NUM_KEYS)-1:0] key_idx_o;
  logic                           multi_o;

  // Drives the raw keys and observes conditioned events.
  modport master (
    output keys_i, repeat_en_i,
    input  held_o, press_o, release_o, key_valid_o, key_idx_o, multi_o
  );

  // The conditioner itself.
  modport slave (
    input  keys_i, repeat_en_i,
    output held_o, press_o, release_o, key_valid_o, key_idx_o, multi_o
  );
endinterface

// File: rtl/keypad_conditioner_channel.sv
// One key: 2-flop sync, counter debounce, press/release pulses, auto-repeat.
// Latency: held/press follow a clean level change 2+DEBOUNCE_CYCLES edges later.
// Backpressure: none; pulses last exactly one cycle.
module keypad_channel
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  input  logic i_repeat_en,
  output logic o_held,
  output logic o_press,
  output logic o_release
);

  localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
  localparam int HC_W = cnt_w(max2(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] DLY_LAST = HC_W'(REPEAT_DELAY - 1);
  localparam logic [HC_W-1:0] PER_LAST = HC_W'(REPEAT_PERIOD - 1);

  // rep_phase selects the first-repeat delay (0) or the steady period (1).
  typedef struct packed {
    logic [1:0]      sync;
    logic [DB_W-1:0] db_cnt;
    logic            held;
    logic            rep_phase;
    logic [HC_W-1:0] hold_cnt;
  } chan_state_t;

  chan_state_t     r_st;
  logic            r_press;
  logic            r_release;

  logic            w_sync;
  logic            w_mismatch;
  logic            w_toggle;
  logic [HC_W-1:0] w_rep_target;
  logic            w_rep_fire;

  assign w_sync       = r_st.sync[1];
  assign w_mismatch   = (w_sync != r_st.held);
  assign w_toggle     = w_mismatch && (r_st.db_cnt == DB_LAST);
  assign w_rep_target = r_st.rep_phase ? PER_LAST : DLY_LAST;
  // A toggling edge never repeats: it is either the initial press or a release.
  assign w_rep_fire   = r_st.held && !w_toggle && i_repeat_en &&
                        (r_st.hold_cnt == w_rep_target);

  // Synchronize, debounce, generate pulses and run the repeat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st      <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_st.sync <= {r_st.sync[0], i_key};

      if (!w_mismatch) begin
        r_st.db_cnt <= '0;
      end else if (w_toggle) begin
        r_st.db_cnt <= '0;
        r_st.held   <= ~r_st.held;
      end else begin
        r_st.db_cnt <= r_st.db_cnt + 1'b1;
      end

      if (w_toggle || !r_st.held || !i_repeat_en) begin
        r_st.hold_cnt  <= '0;
        r_st.rep_phase <= 1'b0;
      end else if (w_rep_fire) begin
        r_st.hold_cnt  <= '0;
        r_st.rep_phase <= 1'b1;
      end else begin
        r_st.hold_cnt  <= r_st.hold_cnt + 1'b1;
      end

      r_press   <= (w_toggle && !r_st.held) || w_rep_fire;
      r_release <= w_toggle && r_st.held;
    end
  end

  assign o_held    = r_st.held;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/keypad_conditioner.sv
// N-key conditioner: per-key channels plus a lowest-index priority encoder.
// Latency: press/release 2+DEBOUNCE_CYCLES edges after a clean level change.
// Backpressure: none; every simultaneous press is reported in the same cycle.
module keypad_conditioner
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                 clk,
  input  logic                 rst,
  keypad_conditioner_if.slave  bus
);

  localparam int IDX_W = key_idx_w(NUM_KEYS);

  logic [NUM_KEYS-1:0] w_held;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic [IDX_W-1:0]    w_idx;
  logic                w_multi;
  logic                w_seen;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    keypad_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_key       (bus.keys_i[g]),
      .i_repeat_en (bus.repeat_en_i),
      .o_held      (w_held[g]),
      .o_press     (w_press[g]),
      .o_release   (w_release[g])
    );
  end

  // Lowest set press bit wins the index; any further set bit flags multi.
  always_comb begin
    w_idx   = '0;
    w_multi = 1'b0;
    w_seen  = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (w_press[i]) begin
        if (!w_seen) w_idx = IDX_W'(i);
        else         w_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
  end

  assign bus.held_o      = w_held;
  assign bus.press_o     = w_press;
  assign bus.release_o   = w_release;
  assign bus.key_valid_o = |w_press;
  assign bus.key_idx_o   = w_idx;
  assign bus.multi_o     = w_multi;

endmodule

// File: tb/tb_keypad_conditioner.sv
// Scoreboard bench for keypad_conditioner at default parameters.
// Stimulus pushes hand-computed events; a negedge monitor pops and compares.
// Edge numbering: cyc counts rising edges; inputs change on falling edges.
module tb_keypad_conditioner;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  keypad_conditioner_if #(.NUM_KEYS(4)) kif ();

  keypad_conditioner #(
    .NUM_KEYS        (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  typedef struct {
    int         t;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] held;
    logic [1:0] idx;
    logic       vld;
    logic       multi;
  } exp_t;

  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int t, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] h, input logic [1:0] idx, input logic m);
    exp_t e;
    e.t = t; e.press = p; e.rel = r; e.held = h; e.idx = idx; e.vld = |p; e.multi = m;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_held"},  32'(kif.held_o),      32'h0);
    chk({name, "_press"}, 32'(kif.press_o),     32'h0);
    chk({name, "_rel"},   32'(kif.release_o),   32'h0);
    chk({name, "_vld"},   32'(kif.key_valid_o), 32'h0);
    chk({name, "_idx"},   32'(kif.key_idx_o),   32'h0);
    chk({name, "_multi"}, 32'(kif.multi_o),     32'h0);
  endtask

  // Monitor: every cycle with a pulse must match the next expected event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ((kif.press_o | kif.release_o) != 4'b0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual press=%b rel=%b required none (cyc %0d)",
                 kif.press_o, kif.release_o, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("ev_cycle", 32'(cyc),             32'(e.t));
        chk("ev_press", 32'(kif.press_o),     32'(e.press));
        chk("ev_rel",   32'(kif.release_o),   32'(e.rel));
        chk("ev_held",  32'(kif.held_o),      32'(e.held));
        chk("ev_idx",   32'(kif.key_idx_o),   32'(e.idx));
        chk("ev_vld",   32'(kif.key_valid_o), 32'(e.vld));
        chk("ev_multi", 32'(kif.multi_o),     32'(e.multi));
      end
    end
  end

  initial begin
    int c;
    int p;
    int d;
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1;
    kif.keys_i = 4'b0;
    kif.repeat_en_i = 1'b0;

    tick(2);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(3);
    chk_all_zero("post_reset");

    // Clean press on key 2.
    c = cyc; kif.keys_i = 4'b0100;
    push(c + 6, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    tick(10);
    chk("held_k2", 32'(kif.held_o), 32'h4);

    // Two-cycle low glitch on held key 2: filtered.
    kif.keys_i = 4'b0000; tick(2); kif.keys_i = 4'b0100; tick(10);
    chk("held_after_glitch", 32'(kif.held_o), 32'h4);

    // Release key 2.
    c = cyc; kif.keys_i = 4'b0000;
    push(c + 6, 4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0);
    tick(10);

    // Bounce on key 0: high 3, low 1, then high.
    c = cyc; kif.keys_i = 4'b0001; tick(3);
    kif.keys_i = 4'b0000; tick(1);
    kif.keys_i = 4'b0001;
    push(c + 10, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    tick(12);
    c = cyc; kif.keys_i = 4'b0000;
    push(c + 6, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0);
    tick(10);

    // Simultaneous keys 3 and 1.
    c = cyc; kif.keys_i = 4'b1010;
    push(c + 6, 4'b1010, 4'b0000, 4'b1010, 2'd1, 1'b1);
    tick(10);
    c = cyc; kif.keys_i = 4'b0000;
    push(c + 6, 4'b0000, 4'b1010, 4'b0000, 2'd0, 1'b0);
    tick(10);

    // Auto-repeat on key 1, held 40 cycles.
    kif.repeat_en_i = 1'b1;
    c = cyc; kif.keys_i = 4'b0010;
    push(c + 6, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    for (int k = 0; k <= 10; k++)
      push(c + 14 + 3 * k, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    tick(40);
    kif.keys_i = 4'b0000;
    push(c + 46, 4'b0000, 4'b0010, 4'b0000, 2'd0, 1'b0);
    tick(10);

    // Same hold with repeat disabled: single press.
    kif.repeat_en_i = 1'b0;
    c = cyc; kif.keys_i = 4'b0010;
    push(c + 6, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    tick(40);
    kif.keys_i = 4'b0000;
    push(c + 46, 4'b0000, 4'b0010, 4'b0000, 2'd0, 1'b0);
    tick(10);

    // Repeat enable dropped and restored while key 3 stays held.
    kif.repeat_en_i = 1'b1;
    c = cyc; p = c + 6; kif.keys_i = 4'b1000;
    push(p,      4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    push(p + 8,  4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    push(p + 27, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    push(p + 30, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    push(p + 33, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    push(p + 34, 4'b0000, 4'b1000, 4'b0000, 2'd0, 1'b0);
    tick(15); kif.repeat_en_i = 1'b0;
    tick(10); kif.repeat_en_i = 1'b1;
    tick(9);  kif.keys_i = 4'b0000;
    tick(10);

    // Asynchronous reset mid-hold, key still high afterwards.
    c = cyc; kif.keys_i = 4'b0100;
    push(c + 6, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    tick(12);
    chk("held_before_rst", 32'(kif.held_o), 32'h4);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    tick(2);
    rst = 1'b0;
    kif.repeat_en_i = 1'b0;
    d = cyc;
    push(d + 6, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    tick(10);
    c = cyc; kif.keys_i = 4'b0000;
    push(c + 6, 4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0);
    tick(12);

    chk("events_left", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
